lif_neuron: RTL and testbench

Leaky integrate-and-fire neuron stage for the SNN perceptron. It runs on the fast system clock and treats the divided clock from the clock divider as its timestep source: one membrane update per rising edge of `tick`. Between timesteps it collects input spikes. On each timestep it leaks, integrates the weighted spikes, and fires a one-cycle output spike on threshold crossing, followed by a refractory period.

---
 rtl/lif_neuron.sv | 142 ++++++++++++++
 tb/tb_lif_neuron.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: collects input spikes between timesteps, then
// leaks, integrates and fires once per rising edge of the divided clock tick.
module lif_neuron #(
  parameter int N_IN       = 4,
  parameter int W          = 8,
  parameter int POT_W      = 12,
  parameter int THRESHOLD  = 100,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [N_IN-1:0]         spike_in,
  input  logic [N_IN*W-1:0]       weights,
  output logic                    spike_out,
  output logic signed [POT_W-1:0] potential,
  output logic                    refractory
);

  localparam int SUM_W = W + $clog2(N_IN) + 1;
  localparam int VW    = POT_W + SUM_W;
  localparam int CNT_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  localparam logic signed [VW-1:0] POT_MAX = {{(SUM_W + 1){1'b0}}, {(POT_W - 1){1'b1}}};
  localparam logic signed [VW-1:0] POT_MIN = {{(SUM_W + 1){1'b1}}, {(POT_W - 1){1'b0}}};
  localparam logic signed [VW-1:0] THR_V   = VW'(THRESHOLD);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_REFR = 1'b1
  } state_t;

  state_t                    state_r;
  logic                      tick_q_r;
  logic [N_IN-1:0]           pend_r;
  logic [CNT_W-1:0]          refr_cnt_r;
  logic                      spike_out_r;
  logic                      refractory_r;
  logic signed [POT_W-1:0]   potential_r;

  logic                      step_s;
  logic [N_IN-1:0]           eff_s;
  logic signed [W-1:0]       w_s;
  logic signed [SUM_W-1:0]   sum_s;
  logic signed [POT_W-1:0]   leak_s;
  logic signed [VW-1:0]      v_next_s;
  logic signed [POT_W-1:0]   sat_s;
  logic signed [VW-1:0]      sat_ext_s;
  logic                      fire_s;

  assign spike_out  = spike_out_r;
  assign potential  = potential_r;
  assign refractory = refractory_r;

  // Step detection, weighted sum of the effective spike set, leak and saturation
  always_comb begin
    step_s = tick & ~tick_q_r;
    eff_s  = pend_r | spike_in;
    w_s    = '0;
    sum_s  = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_s = weights[i*W +: W];
      if (eff_s[i]) begin
        sum_s = sum_s + {{(SUM_W - W){w_s[W-1]}}, w_s};
      end else begin
        sum_s = sum_s;
      end
    end
    leak_s   = potential_r >>> LEAK_SHIFT;
    v_next_s = {{SUM_W{potential_r[POT_W-1]}}, potential_r}
             - {{SUM_W{leak_s[POT_W-1]}}, leak_s}
             + {{POT_W{sum_s[SUM_W-1]}}, sum_s};
    if (v_next_s > POT_MAX) begin
      sat_s = POT_MAX[POT_W-1:0];
    end else if (v_next_s < POT_MIN) begin
      sat_s = POT_MIN[POT_W-1:0];
    end else begin
      sat_s = v_next_s[POT_W-1:0];
    end
    sat_ext_s = {{SUM_W{sat_s[POT_W-1]}}, sat_s};
    fire_s    = (sat_ext_s >= THR_V);
  end

  // Neuron FSM: pending-spike latch, membrane update, firing and refractory count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_RUN;
      tick_q_r     <= 1'b0;
      pend_r       <= '0;
      refr_cnt_r   <= '0;
      spike_out_r  <= 1'b0;
      refractory_r <= 1'b0;
      potential_r  <= '0;
    end else begin
      tick_q_r    <= tick;
      spike_out_r <= 1'b0;
      if (step_s) begin
        pend_r <= '0;
        case (state_r)
          S_RUN: begin
            if (fire_s) begin
              potential_r <= '0;
              spike_out_r <= 1'b1;
              if (REFRACT > 0) begin
                refr_cnt_r   <= CNT_W'(REFRACT);
                refractory_r <= 1'b1;
                state_r      <= S_REFR;
              end else begin
                refr_cnt_r   <= '0;
                refractory_r <= 1'b0;
                state_r      <= S_RUN;
              end
            end else begin
              potential_r <= sat_s;
            end
          end
          S_REFR: begin
            // The effective set is dropped here, so refractory input never carries over
            potential_r  <= '0;
            refr_cnt_r   <= refr_cnt_r - CNT_W'(1);
            refractory_r <= (refr_cnt_r != CNT_W'(1));
            if (refr_cnt_r == CNT_W'(1)) begin
              state_r <= S_RUN;
            end else begin
              state_r <= S_REFR;
            end
          end
          default: begin
            state_r      <= S_RUN;
            potential_r  <= '0;
            refr_cnt_r   <= '0;
            refractory_r <= 1'b0;
          end
        endcase
      end else begin
        pend_r <= pend_r | spike_in;
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: a table of per-step vectors with hand-computed
// membrane values, plus sequences for pending pulses, held tick and async reset.
module tb_lif_neuron;

  logic                clk;
  logic                rst;
  logic                tick;
  logic [3:0]          spike_in;
  logic [31:0]         weights;
  logic                spike_out;
  logic signed [11:0]  potential;
  logic                refractory;

  int n_vec;
  int n_bad;

  typedef struct {
    string              name;
    bit                 rst_first;
    logic [31:0]        wts;
    logic [3:0]         pre;
    logic [3:0]         coin;
    logic signed [11:0] pot;
    logic               spk;
    logic               rfr;
  } vec_t;

  vec_t vecs[$];

  lif_neuron dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .spike_in   (spike_in),
    .weights    (weights),
    .spike_out  (spike_out),
    .potential  (potential),
    .refractory (refractory)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; tick = 1'b0; spike_in = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One timestep: optional pulse well before the step, optional spike in the step cycle
  task automatic do_step(input string name, input logic [3:0] pre, input logic [3:0] coin,
                         input logic signed [11:0] pot, input logic spk, input logic rfr);
    @(negedge clk);
    tick = 1'b0; spike_in = pre;
    @(negedge clk);
    spike_in = 4'b0000;
    @(negedge clk);
    spike_in = coin; tick = 1'b1;
    @(posedge clk); #1;
    chk({name, ".pot"}, potential, pot);
    chk({name, ".spk"}, 32'(spike_out), 32'(spk));
    chk({name, ".ref"}, 32'(refractory), 32'(rfr));
    @(negedge clk);
    tick = 1'b0; spike_in = 4'b0000;
    @(posedge clk); #1;
    chk({name, ".spk_width"}, 32'(spike_out), 32'd0);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b1; tick = 1'b0; spike_in = 4'b0000; weights = 32'h0000_0000;

    // periodic fire with weight0 = 60; spikes during refractory must be ignored
    vecs.push_back('{"fire1", 1'b1, 32'h0000_003C, 4'b0001, 4'b0000, 12'sd60, 1'b0, 1'b0});
    vecs.push_back('{"fire2", 1'b0, 32'h0000_003C, 4'b0001, 4'b0000, 12'sd0,  1'b1, 1'b1});
    vecs.push_back('{"fire3", 1'b0, 32'h0000_003C, 4'b0001, 4'b0000, 12'sd0,  1'b0, 1'b1});
    vecs.push_back('{"fire4", 1'b0, 32'h0000_003C, 4'b0001, 4'b0000, 12'sd0,  1'b0, 1'b0});
    vecs.push_back('{"fire5", 1'b0, 32'h0000_003C, 4'b0001, 4'b0000, 12'sd60, 1'b0, 1'b0});
    vecs.push_back('{"fire6", 1'b0, 32'h0000_003C, 4'b0001, 4'b0000, 12'sd0,  1'b1, 1'b1});
    // pure leak from 90
    vecs.push_back('{"leak1", 1'b1, 32'h0000_005A, 4'b0001, 4'b0000, 12'sd90, 1'b0, 1'b0});
    vecs.push_back('{"leak2", 1'b0, 32'h0000_005A, 4'b0000, 4'b0000, 12'sd79, 1'b0, 1'b0});
    vecs.push_back('{"leak3", 1'b0, 32'h0000_005A, 4'b0000, 4'b0000, 12'sd70, 1'b0, 1'b0});
    vecs.push_back('{"leak4", 1'b0, 32'h0000_005A, 4'b0000, 4'b0000, 12'sd62, 1'b0, 1'b0});
    vecs.push_back('{"leak5", 1'b0, 32'h0000_005A, 4'b0000, 4'b0000, 12'sd55, 1'b0, 1'b0});
    // negative saturation, all weights -128
    vecs.push_back('{"neg1", 1'b1, 32'h8080_8080, 4'b1111, 4'b0000, -12'sd512,  1'b0, 1'b0});
    vecs.push_back('{"neg2", 1'b0, 32'h8080_8080, 4'b1111, 4'b0000, -12'sd960,  1'b0, 1'b0});
    vecs.push_back('{"neg3", 1'b0, 32'h8080_8080, 4'b1111, 4'b0000, -12'sd1352, 1'b0, 1'b0});
    vecs.push_back('{"neg4", 1'b0, 32'h8080_8080, 4'b1111, 4'b0000, -12'sd1695, 1'b0, 1'b0});
    vecs.push_back('{"neg5", 1'b0, 32'h8080_8080, 4'b1111, 4'b0000, -12'sd1995, 1'b0, 1'b0});
    vecs.push_back('{"neg6", 1'b0, 32'h8080_8080, 4'b1111, 4'b0000, -12'sd2048, 1'b0, 1'b0});
    vecs.push_back('{"neg7", 1'b0, 32'h8080_8080, 4'b1111, 4'b0000, -12'sd2048, 1'b0, 1'b0});
    // coincident spike counts; same synapse pending and coincident counts once
    vecs.push_back('{"coin1", 1'b1, 32'h0005_1400, 4'b0000, 4'b0100, 12'sd5,  1'b0, 1'b0});
    vecs.push_back('{"coin2", 1'b0, 32'h0005_1400, 4'b0010, 4'b0100, 12'sd30, 1'b0, 1'b0});
    vecs.push_back('{"coin3", 1'b0, 32'h0005_1400, 4'b0010, 4'b0010, 12'sd47, 1'b0, 1'b0});

    do_reset();
    #1;
    chk("reset.pot", potential, 32'sd0);
    chk("reset.spk", 32'(spike_out), 32'd0);
    chk("reset.ref", 32'(refractory), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) begin
        weights = vecs[i].wts;
        do_reset();
      end else begin
        weights = vecs[i].wts;
      end
      do_step(vecs[i].name, vecs[i].pre, vecs[i].coin, vecs[i].pot, vecs[i].spk, vecs[i].rfr);
    end

    // three separate pulses on synapse 1 between steps add weight1 once
    weights = 32'h0005_1400;
    do_reset();
    repeat (3) begin
      @(negedge clk); spike_in = 4'b0010;
      @(negedge clk); spike_in = 4'b0000;
    end
    do_step("triple", 4'b0000, 4'b0000, 12'sd20, 1'b0, 1'b0);

    // tick held high for 10 cycles gives a single update: 20 - 2 + 5
    @(negedge clk); spike_in = 4'b0100; tick = 1'b1;
    @(posedge clk); #1;
    chk("hold.first", potential, 32'sd23);
    @(negedge clk); spike_in = 4'b0000;
    repeat (9) @(negedge clk);
    chk("hold.last", potential, 32'sd23);
    chk("hold.spk", 32'(spike_out), 32'd0);
    tick = 1'b0;
    do_step("hold.next", 4'b0000, 4'b0000, 12'sd21, 1'b0, 1'b0);

    // async reset with potential 53 and a pending spike that must be lost
    weights = 32'h0000_0035;
    do_reset();
    do_step("r53", 4'b0001, 4'b0000, 12'sd53, 1'b0, 1'b0);
    @(negedge clk); spike_in = 4'b0001;
    @(negedge clk); spike_in = 4'b0000;
    #2 rst = 1'b0;
    #1;
    chk("arst.pot", potential, 32'sd0);
    chk("arst.ref", 32'(refractory), 32'd0);
    @(negedge clk); rst = 1'b1;
    do_step("arst.lost", 4'b0000, 4'b0000, 12'sd0, 1'b0, 1'b0);
    do_step("arst.int", 4'b0001, 4'b0000, 12'sd53, 1'b0, 1'b0);

    // async reset right after firing clears spike_out and refractory
    weights = 32'h0000_0078;
    do_reset();
    @(negedge clk); spike_in = 4'b0001; tick = 1'b1;
    @(posedge clk); #1;
    chk("rfire.spk", 32'(spike_out), 32'd1);
    chk("rfire.ref", 32'(refractory), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rfire.arst_spk", 32'(spike_out), 32'd0);
    chk("rfire.arst_ref", 32'(refractory), 32'd0);
    @(negedge clk); rst = 1'b1; tick = 1'b0; spike_in = 4'b0000;
    do_step("rfire.again", 4'b0001, 4'b0000, 12'sd0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
